// File: rtl/conv_s2_mac.sv
// conv_s2_mac: stage-2 convolution engine. Accepts one 3x3x3 unsigned pixel
// window, accumulates four signed dot products against the live filter ROM
// coefficients (one tap per cycle, four multipliers), then emits four rounded,
// optionally ReLU'd, saturated results over a valid/ready handshake.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   window handshake; in_ready is high only when idle
//   win                 window [canal][columna][fila], unsigned PIX_W
//   Filtro1..Filtro4    coefficient sets, same indexing, signed Q0.16
//   out_valid/out_ready result handshake
//   out1..out4          signed OUT_W results for Filtro1..Filtro4
module conv_s2_mac #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned PIX_W = 8,
  parameter int unsigned FRAC  = 16,
  parameter int unsigned OUT_W = 12,
  parameter int unsigned RELU  = 0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [2:0][2:0][2:0][PIX_W-1:0]       win,
  input  logic [2:0][2:0][2:0][WIDTH-1:0]       Filtro1,
  input  logic [2:0][2:0][2:0][WIDTH-1:0]       Filtro2,
  input  logic [2:0][2:0][2:0][WIDTH-1:0]       Filtro3,
  input  logic [2:0][2:0][2:0][WIDTH-1:0]       Filtro4,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic signed [OUT_W-1:0]               out1,
  output logic signed [OUT_W-1:0]               out2,
  output logic signed [OUT_W-1:0]               out3,
  output logic signed [OUT_W-1:0]               out4
);

  localparam int unsigned PROD_W = PIX_W + 1 + WIDTH;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned K_W    = 5;
  localparam int unsigned LAST_K = 26;
  localparam int unsigned RW     = ACC_W - FRAC + 1;
  localparam int          OMAX   = (2 ** (OUT_W - 1)) - 1;
  localparam int          OMIN   = -(2 ** (OUT_W - 1));
  localparam logic signed [ACC_W:0] HALF = (ACC_W + 1)'(2 ** (FRAC - 1));

  typedef enum logic [1:0] {IDLE, RUN, FIN, HOLD} state_t;

  state_t                          state_q, state_d;
  logic [K_W-1:0]                  k_q, k_d;
  logic [2:0][2:0][2:0][PIX_W-1:0] win_q, win_d;
  logic signed [ACC_W-1:0]         acc_q [4];
  logic signed [ACC_W-1:0]         acc_d [4];
  logic signed [OUT_W-1:0]         out_q [4];
  logic signed [OUT_W-1:0]         out_d [4];
  logic                            out_valid_q, out_valid_d;
  logic                            in_ready_q, in_ready_d;

  logic [PIX_W-1:0]                pix_k;
  logic [WIDTH-1:0]                coef_k [4];
  logic signed [PROD_W-1:0]        prod [4];

  // Round half toward +inf, optional ReLU, then saturate to OUT_W.
  function automatic logic signed [OUT_W-1:0] convert(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] s;
    logic signed [RW-1:0]  r;
    s = (ACC_W + 1)'(a) + HALF;
    r = $signed(s[ACC_W:FRAC]);
    if ((RELU != 0) && r[RW-1]) r = '0;
    if (r > RW'(OMAX))      convert = OUT_W'(OMAX);
    else if (r < RW'(OMIN)) convert = OUT_W'(OMIN);
    else                    convert = OUT_W'(r);
  endfunction

  // Tap select: k = c*9 + j*3 + i; window from the captured copy, coefficients live.
  always_comb begin
    pix_k = '0;
    for (int f = 0; f < 4; f++) coef_k[f] = '0;
    for (int c = 0; c < 3; c++) begin
      for (int j = 0; j < 3; j++) begin
        for (int i = 0; i < 3; i++) begin
          if (k_q == K_W'(c * 9 + j * 3 + i)) begin
            pix_k     = win_q[c][j][i];
            coef_k[0] = Filtro1[c][j][i];
            coef_k[1] = Filtro2[c][j][i];
            coef_k[2] = Filtro3[c][j][i];
            coef_k[3] = Filtro4[c][j][i];
          end
        end
      end
    end
  end

  // Four parallel multipliers: zero-extended pixel times signed coefficient.
  always_comb begin
    for (int f = 0; f < 4; f++) begin
      prod[f] = PROD_W'($signed({1'b0, pix_k})) * PROD_W'($signed(coef_k[f]));
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    win_d       = win_q;
    out_valid_d = out_valid_q;
    for (int f = 0; f < 4; f++) begin
      acc_d[f] = acc_q[f];
      out_d[f] = out_q[f];
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          win_d   = win;
          k_d     = '0;
          state_d = RUN;
          for (int f = 0; f < 4; f++) acc_d[f] = '0;
        end
      end
      RUN: begin
        for (int f = 0; f < 4; f++) acc_d[f] = acc_q[f] + ACC_W'(prod[f]);
        k_d = k_q + K_W'(1);
        if (k_q == K_W'(LAST_K)) state_d = FIN;
      end
      FIN: begin
        for (int f = 0; f < 4; f++) out_d[f] = convert(acc_q[f]);
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      win_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      for (int f = 0; f < 4; f++) begin
        acc_q[f] <= '0;
        out_q[f] <= '0;
      end
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      win_q       <= win_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      for (int f = 0; f < 4; f++) begin
        acc_q[f] <= acc_d[f];
        out_q[f] <= out_d[f];
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out1      = out_q[0];
  assign out2      = out_q[1];
  assign out3      = out_q[2];
  assign out4      = out_q[3];

endmodule

// File: tb/tb_conv_s2_mac.sv
// Bench for conv_s2_mac: two instances (RELU=0 and RELU=1) share all inputs.
// Expected results are computed from the window/filters when a job is issued,
// pushed to a scoreboard and compared when the result handshake completes.
module tb_conv_s2_mac;

  localparam int PIX_W = 8;
  localparam int WIDTH = 17;
  localparam int OUT_W = 12;

  typedef logic [2:0][2:0][2:0][PIX_W-1:0] win_t;
  typedef logic [2:0][2:0][2:0][WIDTH-1:0] filt_t;
  typedef struct packed {
    logic [3:0][OUT_W-1:0] o;
    logic [3:0][OUT_W-1:0] r;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, out_ready;
  win_t win;
  filt_t filt [4];
  logic in_ready, out_valid, in_ready_r, out_valid_r;
  logic [OUT_W-1:0] oa [4];
  logic [OUT_W-1:0] ob [4];

  exp_t sb [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_s2_mac #(.RELU(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .win(win),
    .Filtro1(filt[0]), .Filtro2(filt[1]), .Filtro3(filt[2]), .Filtro4(filt[3]),
    .out_valid(out_valid), .out_ready(out_ready),
    .out1(oa[0]), .out2(oa[1]), .out3(oa[2]), .out4(oa[3])
  );

  conv_s2_mac #(.RELU(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r), .win(win),
    .Filtro1(filt[0]), .Filtro2(filt[1]), .Filtro3(filt[2]), .Filtro4(filt[3]),
    .out_valid(out_valid_r), .out_ready(out_ready),
    .out1(ob[0]), .out2(ob[1]), .out3(ob[2]), .out4(ob[3])
  );

  function automatic logic [OUT_W-1:0] conv_ref(input longint acc, input bit relu);
    longint r;
    r = (acc + 64'sd32768) >>> 16;
    if (relu && r < 0) r = 0;
    if (r > 2047) r = 2047;
    if (r < -2048) r = -2048;
    return OUT_W'(r);
  endfunction

  function automatic exp_t model();
    exp_t e;
    longint acc;
    for (int f = 0; f < 4; f++) begin
      acc = 0;
      for (int c = 0; c < 3; c++)
        for (int j = 0; j < 3; j++)
          for (int i = 0; i < 3; i++)
            acc += longint'(win[c][j][i]) * longint'($signed(filt[f][c][j][i]));
      e.o[f] = conv_ref(acc, 1'b0);
      e.r[f] = conv_ref(acc, 1'b1);
    end
    return e;
  endfunction

  task automatic fill_win(input int v);
    for (int c = 0; c < 3; c++)
      for (int j = 0; j < 3; j++)
        for (int i = 0; i < 3; i++) win[c][j][i] = PIX_W'(v);
  endtask

  task automatic fill_filt(input int f, input int v);
    for (int c = 0; c < 3; c++)
      for (int j = 0; j < 3; j++)
        for (int i = 0; i < 3; i++) filt[f][c][j][i] = WIDTH'(v);
  endtask

  task automatic randomize_all();
    for (int c = 0; c < 3; c++)
      for (int j = 0; j < 3; j++)
        for (int i = 0; i < 3; i++) begin
          win[c][j][i] = PIX_W'($urandom);
          for (int f = 0; f < 4; f++) filt[f][c][j][i] = WIDTH'($urandom);
        end
  endtask

  // Issue one job with the current win/filt, check latency, results and handshake.
  task automatic run_job(input string name, input int hold);
    exp_t e;
    logic [OUT_W-1:0] snap [4];
    int n;
    int bad;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (in_ready !== 1'b1 || in_ready_r !== 1'b1)
      begin errors++; $display("FAIL %s ready_before: got %b/%b want 1", name, in_ready, in_ready_r); end
    e = model();
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    sb.push_back(e);
    in_valid = 1'b0;
    n = 0; bad = 0;
    while (!out_valid && n < 60) begin
      if (in_ready !== 1'b0) bad++;
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n != 28 || out_valid_r !== out_valid)
      begin errors++; $display("FAIL %s latency: got %0d want 28", name, n); end
    checks++;
    if (bad != 0 || in_ready !== 1'b0)
      begin errors++; $display("FAIL %s busy_ready: got %0d high cycles want 0", name, bad); end
    if (out_valid === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      for (int f = 0; f < 4; f++) begin
        checks++;
        if (oa[f] !== e.o[f])
          begin errors++; $display("FAIL %s out%0d: got %0d want %0d", name, f + 1, $signed(oa[f]), $signed(e.o[f])); end
        checks++;
        if (ob[f] !== e.r[f])
          begin errors++; $display("FAIL %s relu_out%0d: got %0d want %0d", name, f + 1, $signed(ob[f]), $signed(e.r[f])); end
        snap[f] = oa[f];
      end
      for (int h = 0; h < hold; h++) begin
        in_valid = 1'($urandom);
        win[0][0][0] = PIX_W'($urandom);
        win[2][1][1] = PIX_W'($urandom);
        @(posedge clk); #1;
        bad = 0;
        for (int f = 0; f < 4; f++) if (oa[f] !== snap[f]) bad++;
        checks++;
        if (bad != 0 || out_valid !== 1'b1 || out_valid_r !== 1'b1 || in_ready !== 1'b0)
          begin errors++; $display("FAIL %s hold%0d: valid=%b ready=%b changed=%0d want 1/0/0", name, h, out_valid, in_ready, bad); end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out_valid_r !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL %s transfer: valid=%b ready=%b want 0/1", name, out_valid, in_ready); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    fill_win(0);
    for (int f = 0; f < 4; f++) fill_filt(f, 0);
    #23;
    for (int f = 0; f < 4; f++) begin
      checks++;
      if (oa[f] !== '0 || ob[f] !== '0)
        begin errors++; $display("FAIL reset out%0d: got %0d want 0", f + 1, $signed(oa[f])); end
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || in_ready_r !== 1'b1 || out_valid_r !== 1'b0)
      begin errors++; $display("FAIL reset hs: ready=%b valid=%b want 1/0", in_ready, out_valid); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_window();
    randomize_all();
    fill_win(0);
    run_job("zero_win", 0);
  endtask

  task automatic test_half_scale();
    fill_win(100);
    fill_filt(0, 32768);
    fill_filt(1, -32768);
    fill_filt(2, 0);
    fill_filt(3, 1000);
    run_job("half_scale", 0);
  endtask

  task automatic test_saturate();
    fill_win(255);
    for (int f = 0; f < 4; f++) fill_filt(f, 0);
    fill_filt(3, 65535);
    fill_filt(0, -65536);
    run_job("sat", 0);
  endtask

  task automatic test_single_tap();
    fill_win(0);
    for (int f = 0; f < 4; f++) fill_filt(f, 0);
    win[1][2][0] = PIX_W'(3);
    filt[0][1][2][0] = WIDTH'(21846);
    filt[1][1][0][2] = WIDTH'(21846);
    filt[2][2][1][0] = WIDTH'(-21846);
    run_job("single_tap", 0);
  endtask

  task automatic test_hold();
    randomize_all();
    run_job("hold", 5);
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 3; t++) begin
      randomize_all();
      run_job("b2b", 0);
    end
  endtask

  task automatic test_mid_reset();
    int seen;
    randomize_all();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || in_ready_r !== 1'b1)
      begin errors++; $display("FAIL mid_reset state: valid=%b ready=%b want 0/1", out_valid, in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || out_valid_r !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0)
      begin errors++; $display("FAIL mid_reset aborted_valid: got %0d cycles want 0", seen); end
    randomize_all();
    run_job("after_reset", 0);
  endtask

  initial begin
    test_reset();
    test_zero_window();
    test_half_scale();
    test_saturate();
    test_single_tap();
    test_hold();
    test_back_to_back();
    test_mid_reset();
    checks++;
    if (sb.size() != 0)
      begin errors++; $display("FAIL scoreboard_leftover: got %0d want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
